// File: rtl/xfire_fpu_bkm_ctrl_pkg.sv
// Shared definitions for the BKM sequencer: opcode width, operand format codes, FSM state encoding.
`ifndef OPSIZE
`define OPSIZE 4
`endif

package xfire_fpu_bkm_ctrl_pkg;

  localparam int OP_W = `OPSIZE;

  localparam logic [1:0] FMT_SP   = 2'b00;
  localparam logic [1:0] FMT_DP   = 2'b01;
  localparam logic [1:0] FMT_XP   = 2'b10;
  localparam logic [1:0] FMT_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ITER = 3'd2,
    ST_NORM = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/xfire_fpu_bkm_ctrl_iter_cnt.sv
// BKM iteration index: clear, saturating increment, terminal-count flag at N-1.
module xfire_fpu_bkm_iter_cnt #(
  parameter int N     = 64,
  parameter int LOG2N = 6
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             srst,
  input  logic             clr,
  input  logic             inc,
  output logic [LOG2N-1:0] cnt,
  output logic             tc
);

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  assign tc = (cnt == LAST);

  always_ff @(posedge clk or posedge arst) begin
    if (arst)              cnt <= '0;
    else if (srst || clr)  cnt <= '0;
    else if (inc && !tc)   cnt <= cnt + LOG2N'(1);
  end

endmodule

// File: rtl/xfire_fpu_bkm_ctrl.sv
// BKM operation sequencer: load, N iteration steps, normalise, done/abort, with stall and exception handling.
// state | meaning
// IDLE  | waiting for start
// LOAD  | operands loaded into datapath (ld)
// ITER  | one BKM iteration per enabled cycle (step, iter)
// NORM  | normalise/round (norm)
// DONE  | completion pulse (done, abort on failure)
`ifndef OPSIZE
`define OPSIZE 4
`endif

module xfire_fpu_bkm_ctrl
  import xfire_fpu_bkm_ctrl_pkg::*;
#(
  parameter int N     = 64,
  parameter int LOG2N = 6
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               srst,
  input  logic               enable,
  input  logic               start,
  input  logic [`OPSIZE-1:0] op,
  input  logic [1:0]         format,
  input  logic               dp_err,
  output logic               ld,
  output logic               step,
  output logic [LOG2N-1:0]   iter,
  output logic               norm,
  output logic [`OPSIZE-1:0] op_q,
  output logic [1:0]         fmt_q,
  output logic               busy,
  output logic               done,
  output logic               abort
);

  state_t             state, state_d;
  logic               ld_d, step_d, norm_d, done_d, abort_d, busy_d;
  logic [`OPSIZE-1:0] op_d;
  logic [1:0]         fmt_d;
  logic               cnt_clr, cnt_inc, cnt_tc;

  xfire_fpu_bkm_iter_cnt #(.N(N), .LOG2N(LOG2N)) u_iter_cnt (
    .clk  (clk),
    .arst (arst),
    .srst (srst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .cnt  (iter),
    .tc   (cnt_tc)
  );

  // Strobes are registered for the state being entered, so every output comes from a flop.
  always_comb begin
    state_d = state;
    ld_d    = 1'b0;
    step_d  = 1'b0;
    norm_d  = 1'b0;
    done_d  = 1'b0;
    abort_d = 1'b0;
    op_d    = op_q;
    fmt_d   = fmt_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (enable) begin
      case (state)
        ST_IDLE: if (start) begin
          state_d = ST_LOAD;
          op_d    = op;
          fmt_d   = format;
          ld_d    = (format != FMT_RSVD);
        end
        ST_LOAD: if (fmt_q == FMT_RSVD) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          abort_d = 1'b1;
        end else begin
          state_d = ST_ITER;
          step_d  = 1'b1;
        end
        ST_ITER: if (dp_err) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          abort_d = 1'b1;
          cnt_clr = 1'b1;
        end else if (cnt_tc) begin
          state_d = ST_NORM;
          norm_d  = 1'b1;
          cnt_clr = 1'b1;
        end else begin
          step_d  = 1'b1;
          cnt_inc = 1'b1;
        end
        ST_NORM: begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= ST_IDLE;
      op_q  <= '0;
      fmt_q <= '0;
      ld    <= 1'b0;
      step  <= 1'b0;
      norm  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      abort <= 1'b0;
    end else if (srst) begin
      state <= ST_IDLE;
      op_q  <= '0;
      fmt_q <= '0;
      ld    <= 1'b0;
      step  <= 1'b0;
      norm  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      abort <= 1'b0;
    end else begin
      state <= state_d;
      op_q  <= op_d;
      fmt_q <= fmt_d;
      ld    <= ld_d;
      step  <= step_d;
      norm  <= norm_d;
      busy  <= busy_d;
      done  <= done_d;
      abort <= abort_d;
    end
  end

endmodule

// File: tb/tb_xfire_fpu_bkm_ctrl.sv
// Directed self-checking bench for the BKM sequencer (N=64).
module tb_xfire_fpu_bkm_ctrl;
  import xfire_fpu_bkm_ctrl_pkg::*;

  localparam int N = 64;
  localparam int LOG2N = 6;

  logic              clk = 1'b0;
  logic              arst, srst, enable, start, dp_err;
  logic [OP_W-1:0]   op;
  logic [1:0]        format;
  logic              ld, step, norm, busy, done, abort;
  logic [LOG2N-1:0]  iter;
  logic [OP_W-1:0]   op_q;
  logic [1:0]        fmt_q;

  int checks = 0;
  int errors = 0;

  xfire_fpu_bkm_ctrl #(.N(N), .LOG2N(LOG2N)) dut (
    .clk(clk), .arst(arst), .srst(srst), .enable(enable), .start(start),
    .op(op), .format(format), .dp_err(dp_err), .ld(ld), .step(step),
    .iter(iter), .norm(norm), .op_q(op_q), .fmt_q(fmt_q), .busy(busy),
    .done(done), .abort(abort)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst = 1'b1; srst = 1'b0; enable = 1'b1; start = 1'b0; dp_err = 1'b0;
    op = '0; format = 2'b00;
    #3;
    checks++;
    if ({ld, step, norm, busy, done, abort, iter, op_q, fmt_q} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ld%b st%b nm%b bz%b dn%b ab%b it%0d op%0d fm%0d required all 0",
               ld, step, norm, busy, done, abort, iter, op_q, fmt_q);
    end
    tick(); tick();
    arst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy got %b required 0", busy); end
  endtask

  // op=3 fmt=0; dp_err held high in IDLE/LOAD must be ignored.
  task automatic test_nominal();
    start = 1'b1; op = 4'd3; format = 2'b00; dp_err = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (ld !== 1'b1 || busy !== 1'b1 || op_q !== 4'd3 || fmt_q !== 2'b00 || step !== 1'b0) begin
      errors++;
      $display("FAIL nom_load got ld%b bz%b op%0d fm%0d st%b required ld1 bz1 op3 fm0 st0", ld, busy, op_q, fmt_q, step);
    end
    for (int k = 0; k < N; k++) begin
      tick();
      if (k == 0) dp_err = 1'b0;
      checks++;
      if (step !== 1'b1 || iter !== LOG2N'(k) || ld !== 1'b0 || norm !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL nom_step k=%0d got st%b it%0d ld%b nm%b dn%b required st1 it%0d", k, step, iter, ld, norm, done, k);
      end
    end
    tick();
    checks++;
    if (norm !== 1'b1 || step !== 1'b0 || iter !== '0 || done !== 1'b0) begin
      errors++;
      $display("FAIL nom_norm got nm%b st%b it%0d dn%b required nm1 st0 it0 dn0", norm, step, iter, done);
    end
    tick();
    checks++;
    if (done !== 1'b1 || abort !== 1'b0 || norm !== 1'b0 || op_q !== 4'd3) begin
      errors++;
      $display("FAIL nom_done got dn%b ab%b nm%b op%0d required dn1 ab0 nm0 op3", done, abort, norm, op_q);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL nom_idle got dn%b bz%b required dn0 bz0", done, busy);
    end
  endtask

  task automatic test_stall();
    start = 1'b1; op = 4'd6; format = 2'b01;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 10; k++) tick();
    checks++;
    if (iter !== 6'd10 || step !== 1'b1) begin
      errors++;
      $display("FAIL stall_pre got it%0d st%b required it10 st1", iter, step);
    end
    enable = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      checks++;
      if (iter !== 6'd10 || step !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || op_q !== 4'd6) begin
        errors++;
        $display("FAIL stall_hold s=%0d got it%0d st%b bz%b dn%b op%0d required it10 st0 bz1 dn0 op6", s, iter, step, busy, done, op_q);
      end
    end
    enable = 1'b1;
    for (int k = 11; k < N; k++) begin
      tick();
      checks++;
      if (step !== 1'b1 || iter !== LOG2N'(k)) begin
        errors++;
        $display("FAIL stall_resume k=%0d got st%b it%0d required st1 it%0d", k, step, iter, k);
      end
    end
    tick();
    checks++;
    if (norm !== 1'b1) begin errors++; $display("FAIL stall_norm got %b required 1", norm); end
    tick();
    checks++;
    if (done !== 1'b1 || abort !== 1'b0) begin
      errors++;
      $display("FAIL stall_done got dn%b ab%b required dn1 ab0", done, abort);
    end
    tick();
  endtask

  task automatic test_dp_err();
    start = 1'b1; op = 4'd5; format = 2'b01;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 20; k++) tick();
    checks++;
    if (iter !== 6'd20) begin errors++; $display("FAIL err_pre iter got %0d required 20", iter); end
    dp_err = 1'b1;
    tick();
    dp_err = 1'b0;
    checks++;
    if (done !== 1'b1 || abort !== 1'b1 || norm !== 1'b0 || step !== 1'b0 || iter !== '0) begin
      errors++;
      $display("FAIL err_done got dn%b ab%b nm%b st%b it%0d required dn1 ab1 nm0 st0 it0", done, abort, norm, step, iter);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || abort !== 1'b0 || norm !== 1'b0) begin
      errors++;
      $display("FAIL err_idle got bz%b dn%b ab%b nm%b required all 0", busy, done, abort, norm);
    end
  endtask

  task automatic test_reserved();
    start = 1'b1; op = 4'd7; format = 2'b11;
    tick();
    start = 1'b0;
    checks++;
    if (ld !== 1'b0 || step !== 1'b0 || busy !== 1'b1 || fmt_q !== 2'b11 || done !== 1'b0) begin
      errors++;
      $display("FAIL rsvd_load got ld%b st%b bz%b fm%0d dn%b required ld0 st0 bz1 fm3 dn0", ld, step, busy, fmt_q, done);
    end
    tick();
    checks++;
    if (done !== 1'b1 || abort !== 1'b1 || step !== 1'b0) begin
      errors++;
      $display("FAIL rsvd_done got dn%b ab%b st%b required dn1 ab1 st0", done, abort, step);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rsvd_idle got bz%b dn%b required 0 0", busy, done);
    end
  endtask

  // Second start at iter=5 and another in the DONE cycle must both be dropped.
  task automatic test_busy_start();
    int dones;
    dones = 0;
    start = 1'b1; op = 4'd2; format = 2'b01;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 5; k++) tick();
    start = 1'b1; op = 4'd9;
    tick();
    start = 1'b0;
    checks++;
    if (op_q !== 4'd2 || iter !== 6'd6) begin
      errors++;
      $display("FAIL busy_start got op%0d it%0d required op2 it6", op_q, iter);
    end
    for (int c = 0; c < 80; c++) begin
      tick();
      if (done) begin dones++; start = 1'b1; end
      else start = 1'b0;
    end
    start = 1'b0;
    checks++;
    if (dones !== 1 || busy !== 1'b0 || op_q !== 4'd2) begin
      errors++;
      $display("FAIL busy_single_done got dones%0d bz%b op%0d required 1 0 2", dones, busy, op_q);
    end
  endtask

  task automatic test_srst();
    start = 1'b1; op = 4'd4; format = 2'b10;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    enable = 1'b0; srst = 1'b1;
    tick();
    srst = 1'b0; enable = 1'b1;
    checks++;
    if ({ld, step, norm, busy, done, abort, iter, op_q, fmt_q} !== '0) begin
      errors++;
      $display("FAIL srst_clear got bz%b st%b it%0d op%0d fm%0d required all 0", busy, step, iter, op_q, fmt_q);
    end
  endtask

  task automatic test_arst_mid();
    int lat;
    bit  saw_done;
    start = 1'b1; op = 4'd11; format = 2'b00;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 30; k++) tick();
    checks++;
    if (iter !== 6'd30) begin errors++; $display("FAIL arst_pre iter got %0d required 30", iter); end
    #2 arst = 1'b1;
    #1;
    checks++;
    if ({ld, step, norm, busy, done, abort, iter, op_q, fmt_q} !== '0) begin
      errors++;
      $display("FAIL arst_immediate got st%b bz%b it%0d op%0d required all 0", step, busy, iter, op_q);
    end
    tick();
    arst = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin errors++; $display("FAIL arst_no_done got activity %b required 0", saw_done); end
    start = 1'b1; op = 4'd1; format = 2'b00;
    tick();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== N + 3 || abort !== 1'b0) begin
      errors++;
      $display("FAIL arst_rerun latency got %0d ab%b required %0d ab0", lat, abort, N + 3);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stall();
    test_dp_err();
    test_reserved();
    test_busy_start();
    test_srst();
    test_arst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
